// File: rtl/qam_mapper_axis.sv
// Gray-coded BPSK/QPSK/16QAM/64QAM constellation mapper on AXI-Stream, with a
// 2-entry (output + skid) buffer, per-packet mode lock and packet symbol count.
module qam_mapper_axis #(
    parameter int DW    = 16,
    parameter int CNT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              s_axis_tvalid,
    input  logic [5:0]        s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_bit_symb_last,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [2*DW-1:0]   m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_bit_symb_last,
    input  logic              m_axis_tready,
    output logic              stat_pkt_done,
    output logic [CNT_W-1:0]  stat_pkt_syms
);

    localparam int SHL = (DW >= 16) ? DW - 16 : 0;
    localparam int SHR = (DW < 16) ? 16 - DW : 0;

    // Amplitudes are defined for DW=16 and rescaled (truncating) for other widths.
    function automatic logic signed [DW-1:0] scale_amp(input int amp16);
        int tmp;
        tmp = (amp16 <<< SHL) >>> SHR;
        return signed'(tmp[DW-1:0]);
    endfunction

    localparam logic signed [DW-1:0] AMP_BPSK = scale_amp(16384);
    localparam logic signed [DW-1:0] AMP_QPSK = scale_amp(11585);
    localparam logic signed [DW-1:0] AMP_A1   = scale_amp(5181);
    localparam logic signed [DW-1:0] AMP_A3   = scale_amp(15543);
    localparam logic signed [DW-1:0] AMP_B1   = scale_amp(2528);
    localparam logic signed [DW-1:0] AMP_B3   = scale_amp(7584);
    localparam logic signed [DW-1:0] AMP_B5   = scale_amp(12640);
    localparam logic signed [DW-1:0] AMP_B7   = scale_amp(17696);

    function automatic logic signed [DW-1:0] signed_amp(input logic pos,
                                                        input logic signed [DW-1:0] mag);
        return pos ? mag : -mag;
    endfunction

    function automatic logic signed [DW-1:0] lvl_qam16(input logic [1:0] g);
        return signed_amp(g[1], g[0] ? AMP_A1 : AMP_A3);
    endfunction

    // MSB picks the sign; the two lower Gray bits pick the magnitude.
    function automatic logic signed [DW-1:0] lvl_qam64(input logic [2:0] g);
        logic signed [DW-1:0] mag;
        case (g[1:0])
            2'b00:   mag = AMP_B7;
            2'b01:   mag = AMP_B5;
            2'b11:   mag = AMP_B3;
            default: mag = AMP_B1;
        endcase
        return signed_amp(g[2], mag);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                  out_vld_q, out_vld_d;
    logic [2*DW-1:0]       out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  out_sl_q, out_sl_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [2*DW-1:0]       skid_data_q, skid_data_d;
    logic                  skid_last_q, skid_last_d;
    logic                  skid_sl_q, skid_sl_d;
    logic                  rdy_q, rdy_d;
    logic                  in_pkt_q, in_pkt_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      syms_q, syms_d;

    logic                  s_acc, m_acc, out_free;
    logic [1:0]            eff_mode;
    logic signed [DW-1:0]  map_i, map_q;
    logic [2*DW-1:0]       map_word;

    assign s_acc    = s_axis_tvalid && rdy_q;
    assign m_acc    = out_vld_q && m_axis_tready;
    assign out_free = !out_vld_q || m_axis_tready;
    assign eff_mode = in_pkt_q ? mode_q : cfg_mode;

    always_comb begin
        map_i = '0;
        map_q = '0;
        case (eff_mode)
            2'd0: map_i = signed_amp(s_axis_tdata[0], AMP_BPSK);
            2'd1: begin
                map_i = signed_amp(s_axis_tdata[0], AMP_QPSK);
                map_q = signed_amp(s_axis_tdata[1], AMP_QPSK);
            end
            2'd2: begin
                map_i = lvl_qam16(s_axis_tdata[1:0]);
                map_q = lvl_qam16(s_axis_tdata[3:2]);
            end
            default: begin
                map_i = lvl_qam64(s_axis_tdata[2:0]);
                map_q = lvl_qam64(s_axis_tdata[5:3]);
            end
        endcase
        map_word = {map_q, map_i};
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sl_d    = out_sl_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        skid_sl_d   = skid_sl_q;
        in_pkt_d    = in_pkt_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        syms_d      = syms_q;

        // The skid entry is always older than the incoming beat, so it drains first.
        if (out_free) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_last_d = skid_last_q;
                out_sl_d   = skid_sl_q;
                skid_vld_d = s_acc;
            end else begin
                out_vld_d = s_acc;
                if (s_acc) begin
                    out_data_d = map_word;
                    out_last_d = s_axis_tlast;
                    out_sl_d   = s_bit_symb_last;
                end
            end
        end else if (s_acc) begin
            skid_vld_d = 1'b1;
        end
        if (s_acc) begin
            skid_data_d = map_word;
            skid_last_d = s_axis_tlast;
            skid_sl_d   = s_bit_symb_last;
            if (!in_pkt_q) begin
                mode_d = cfg_mode;
            end
            in_pkt_d = !s_axis_tlast;
        end

        if (m_acc) begin
            if (out_last_q) begin
                done_d = 1'b1;
                syms_d = sat_inc(cnt_q);
                cnt_d  = '0;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
        rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_sl_q   <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            in_pkt_q   <= 1'b0;
            mode_q     <= 2'd0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            syms_q     <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_sl_q   <= out_sl_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            in_pkt_q   <= in_pkt_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            syms_q     <= syms_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
        skid_last_q <= skid_last_d;
        skid_sl_q   <= skid_sl_d;
    end

    assign s_axis_tready   = rdy_q;
    assign m_axis_tvalid   = out_vld_q;
    assign m_axis_tdata    = out_data_q;
    assign m_axis_tlast    = out_last_q;
    assign m_bit_symb_last = out_sl_q;
    assign stat_pkt_done   = done_q;
    assign stat_pkt_syms   = syms_q;

endmodule

// File: tb/tb_qam_mapper_axis.sv
// Scoreboard bench for qam_mapper_axis: a constellation model built from Gray
// decoding and level arithmetic feeds a queue that an output monitor drains.
module tb_qam_mapper_axis;
    localparam int DW    = 16;
    localparam int CNT_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        cfg_mode = 2'd0;
    logic              s_axis_tvalid = 1'b0;
    logic [5:0]        s_axis_tdata = '0;
    logic              s_axis_tlast = 1'b0;
    logic              s_bit_symb_last = 1'b0;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic [2*DW-1:0]   m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_bit_symb_last;
    logic              m_axis_tready = 1'b0;
    logic              stat_pkt_done;
    logic [CNT_W-1:0]  stat_pkt_syms;

    always #5 clk = ~clk;

    qam_mapper_axis #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast), .s_bit_symb_last(s_bit_symb_last),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .m_bit_symb_last(m_bit_symb_last),
        .m_axis_tready(m_axis_tready),
        .stat_pkt_done(stat_pkt_done), .stat_pkt_syms(stat_pkt_syms)
    );

    logic [33:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          mdl_in_pkt = 1'b0;
    logic [1:0]  mdl_mode = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray2bin(input int g);
        return g ^ (g >> 1) ^ (g >> 2);
    endfunction

    // Levels are odd multiples of the unit step: (2*index - (M-1)) * step.
    function automatic int level(input logic [1:0] mode, input logic [5:0] d, input bit qc);
        int g;
        case (mode)
            2'd0: return qc ? 0 : (d[0] ? 16384 : -16384);
            2'd1: return (qc ? d[1] : d[0]) ? 11585 : -11585;
            2'd2: begin
                g = qc ? int'(d[3:2]) : int'(d[1:0]);
                return (2 * gray2bin(g) - 3) * 5181;
            end
            default: begin
                g = qc ? int'(d[5:3]) : int'(d[2:0]);
                return (2 * gray2bin(g) - 7) * 2528;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_beat(input logic [1:0] mode, input logic [5:0] d);
        logic [15:0] iv, qv;
        iv = 16'(level(mode, d, 1'b0));
        qv = 16'(level(mode, d, 1'b1));
        return {qv, iv};
    endfunction

    task automatic step(input bit v, input logic [5:0] d, input bit last, input bit sl,
                        input logic [1:0] mode, input bit mr, output bit acc);
        s_axis_tvalid   = v;
        s_axis_tdata    = d;
        s_axis_tlast    = last;
        s_bit_symb_last = sl;
        cfg_mode        = mode;
        m_axis_tready   = mr;
        @(negedge clk);
        acc = v && s_axis_tready && rst;
        if (acc) begin
            if (!mdl_in_pkt) mdl_mode = mode;
            exp_q.push_back({last, sl, model_beat(mdl_mode, d)});
            mdl_in_pkt = !last;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] d, input bit last, input bit sl,
                        input logic [1:0] mode, input bit mr);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) step(1'b1, d, last, sl, mode, mr, acc);
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int t = 0; t < n; t++) step(1'b0, 6'd0, 1'b0, 1'b0, cfg_mode, 1'b1, acc);
    endtask

    // Output monitor: pops on every accepted output beat, checks holds and status.
    initial begin
        bit          held_v;
        logic [33:0] held;
        bit          pend_stat;
        int          pend_syms;
        int          cnt;
        logic [33:0] e;
        held_v = 0; pend_stat = 0; cnt = 0; pend_syms = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held_v = 0; pend_stat = 0; cnt = 0;
            end else begin
                if (held_v) chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_bit_symb_last, m_axis_tdata},
                                {1'b1, held});
                held_v = 0;
                if (pend_stat) begin
                    chk("stat_done", stat_pkt_done, 1);
                    chk("stat_syms", stat_pkt_syms, pend_syms);
                    pend_stat = 0;
                end else begin
                    chk("stat_idle", stat_pkt_done, 0);
                end
                if (m_axis_tvalid) begin
                    if (m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", {m_axis_tlast, m_bit_symb_last, m_axis_tdata}, 34'h0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_beat", {m_axis_tlast, m_bit_symb_last, m_axis_tdata}, e);
                            cnt++;
                            if (e[33]) begin
                                pend_stat = 1;
                                pend_syms = (cnt > 4095) ? 4095 : cnt;
                                cnt = 0;
                            end
                        end
                    end else begin
                        held_v = 1;
                        held = {m_axis_tlast, m_bit_symb_last, m_axis_tdata};
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit exp_acc [6];
        bit mr_pat [6];
        logic [5:0] k;
        logic [31:0] qpsk_exp [4];
        exp_acc = '{1, 1, 0, 0, 1, 0};
        mr_pat  = '{1, 0, 0, 1, 0, 1};
        qpsk_exp = '{32'hD2BFD2BF, 32'hD2BF2D41, 32'h2D41D2BF, 32'h2D412D41};

        // Reset values
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_symb_last", m_bit_symb_last, 0);
        chk("rst_stat_done", stat_pkt_done, 0);
        chk("rst_stat_syms", stat_pkt_syms, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", s_axis_tready, 1);

        // QPSK walk with one-cycle latency
        for (int i = 0; i < 4; i++) begin
            send(6'(i), i == 3, 1'b0, 2'd1, 1'b1);
            chk("qpsk_vld", m_axis_tvalid, 1);
            chk("qpsk_data", m_axis_tdata, qpsk_exp[i]);
            chk("qpsk_s_tready", s_axis_tready, 1);
        end
        idle(2);

        // 64QAM corner points
        send(6'b100_000, 1'b0, 1'b0, 2'd3, 1'b1);
        chk("qam64_a", m_axis_tdata, 32'h4520BAE0);
        send(6'b011_110, 1'b1, 1'b0, 2'd3, 1'b1);
        chk("qam64_b", m_axis_tdata, 32'hE26009E0);
        idle(2);

        // Mode lock: mode switched mid-packet, then a BPSK packet
        for (int i = 0; i < 4; i++)
            send(6'($urandom), i == 3, 1'b0, (i < 2) ? 2'd2 : 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(6'($urandom), i == 2, 1'b0, 2'd0, 1'b1);
            chk("bpsk_q_zero", m_axis_tdata[31:16], 0);
        end
        idle(3);

        // Backpressure pattern on a continuous stream
        k = 6'd0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, k, 1'b0, 1'b0, 2'd3, mr_pat[i], acc);
            chk("bp_accept", acc, exp_acc[i]);
            if (acc) k = k + 6'd1;
        end
        send(k, 1'b1, 1'b0, 2'd3, 1'b1);
        idle(3);

        // Symbol-last alignment and packet status
        for (int i = 1; i <= 7; i++) begin
            send(6'($urandom), i == 7, i == 4, 2'd2, 1'b1);
            if (i == 4) chk("symb_last_beat4", m_bit_symb_last, 1);
            if (i == 5) chk("symb_last_beat5", m_bit_symb_last, 0);
        end
        idle(1);
        chk("pkt7_done", stat_pkt_done, 1);
        chk("pkt7_syms", stat_pkt_syms, 7);
        idle(2);

        // Reset while both buffer entries are occupied
        send(6'd5, 1'b0, 1'b0, 2'd3, 1'b0);
        send(6'd6, 1'b0, 1'b0, 2'd3, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        mdl_in_pkt = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_m_tvalid", m_axis_tvalid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_s_tready", s_axis_tready, 1);
        chk("midrst_no_stale", m_axis_tvalid, 0);
        idle(3);
        chk("midrst_still_empty", m_axis_tvalid, 0);
        send(6'd1, 1'b1, 1'b0, 2'd0, 1'b1);
        chk("midrst_fresh_mode", m_axis_tdata, 32'h00004000);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 7, 6'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 9) < 7, acc);
        send(6'($urandom), 1'b1, 1'b0, 2'($urandom), 1'b1);
        idle(10);

        // Long packet exercising counter saturation
        for (int i = 0; i < 4100; i++)
            send(6'($urandom), i == 4099, 1'b0, 2'd1, 1'b1);
        idle(1);
        chk("sat_syms", stat_pkt_syms, 4095);
        idle(10);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
